// File: rtl/midi_event_decoder.sv
// rtl/midi_event_decoder.sv - multitimbral MIDI channel-voice parser with event FIFO
// Running-status parser feeding a first-word fall-through FIFO with a registered head.
module midi_event_decoder #(
  parameter int NUM_PARTS  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic                   CLOCK_25,
  input  logic                   reset_reg_N,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  input  logic [4*NUM_PARTS-1:0] part_ch,
  input  logic [NUM_PARTS-1:0]   part_omni,
  input  logic [NUM_PARTS-1:0]   part_en,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [2:0]             ev_type,
  output logic [NUM_PARTS-1:0]   ev_part_mask,
  output logic [6:0]             ev_d1,
  output logic [13:0]            ev_d2,
  output logic [7:0]             drop_cnt,
  output logic                   sysex_active
);

  localparam int EW = 3 + NUM_PARTS + 7 + 14;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA1, DATA2, SYSEX} state_t;

  state_t          state_q;
  logic [7:0]      rs_q;
  logic [6:0]      d1_q;
  logic            sysex_q;
  logic            in_ready_q;

  logic            one_byte;
  logic            complete;
  logic [2:0]      new_type;
  logic [6:0]      new_d1;
  logic [13:0]     new_d2;
  logic [NUM_PARTS-1:0] new_mask;
  logic [EW-1:0]   new_ev;
  logic            fire;

  assign one_byte = (rs_q[7:4] == 4'hC) || (rs_q[7:4] == 4'hD);
  assign complete = in_valid && !in_data[7] &&
                    (((state_q == DATA1) && one_byte) || (state_q == DATA2));

  always_comb begin
    new_type = 3'd0;
    new_d1   = d1_q;
    new_d2   = {7'd0, in_data[6:0]};
    case (rs_q[7:4])
      4'h8: new_type = 3'd0;
      4'h9: new_type = (in_data[6:0] == 7'd0) ? 3'd0 : 3'd1;
      4'hA: new_type = 3'd6;
      4'hB: new_type = 3'd2;
      4'hC: begin new_type = 3'd3; new_d1 = in_data[6:0]; new_d2 = 14'd0; end
      4'hD: begin new_type = 3'd5; new_d1 = in_data[6:0]; new_d2 = 14'd0; end
      4'hE: begin new_type = 3'd4; new_d1 = 7'd0; new_d2 = {in_data[6:0], d1_q}; end
      default: new_type = 3'd0;
    endcase
  end

  always_comb begin
    new_mask = '0;
    for (int i = 0; i < NUM_PARTS; i++)
      new_mask[i] = part_en[i] && (part_omni[i] || (part_ch[4*i +: 4] == rs_q[3:0]));
  end

  assign new_ev = {new_type, new_mask, new_d1, new_d2};
  assign fire   = complete && (new_mask != '0);

  // Realtime bytes (F8-FF) fall through every branch and leave parser state untouched.
  always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q    <= IDLE;
      rs_q       <= 8'd0;
      d1_q       <= 7'd0;
      sysex_q    <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      in_ready_q <= 1'b1;
      if (in_valid) begin
        if (in_data[7]) begin
          if (in_data == 8'hF0) begin
            state_q <= SYSEX;
            sysex_q <= 1'b1;
            rs_q    <= 8'd0;
          end else if (in_data >= 8'hF1 && in_data <= 8'hF7) begin
            state_q <= IDLE;
            sysex_q <= 1'b0;
            rs_q    <= 8'd0;
          end else if (in_data < 8'hF0) begin
            state_q <= DATA1;
            sysex_q <= 1'b0;
            rs_q    <= in_data;
          end
        end else begin
          case (state_q)
            DATA1: if (!one_byte) begin
              d1_q    <= in_data[6:0];
              state_q <= DATA2;
            end
            DATA2: state_q <= DATA1;
            default: state_q <= state_q;
          endcase
        end
      end
    end
  end

  logic [EW-1:0]      mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q, rd_next;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [EW-1:0]      head_q, head_d;
  logic               ev_valid_q;
  logic [7:0]         drop_q;
  logic               pop, wr, drop;

  assign pop     = ev_valid_q && ev_ready;
  assign wr      = fire && ((count_q != FULL_CNT) || pop);
  assign drop    = fire && (count_q == FULL_CNT) && !pop;
  assign rd_next = rd_ptr_q + 1'b1;
  assign count_d = count_q + (FIFO_AW+1)'(wr) - (FIFO_AW+1)'(pop);

  // Head register tracks mem[rd_ptr], bypassing a fresh write when the FIFO drains to it.
  always_comb begin
    head_d = head_q;
    if (pop) begin
      if (count_q > (FIFO_AW+1)'(1)) head_d = mem[rd_next];
      else if (wr)                   head_d = new_ev;
    end else if ((count_q == '0) && wr) begin
      head_d = new_ev;
    end
  end

  always_ff @(posedge CLOCK_25) begin
    if (wr) mem[wr_ptr_q] <= new_ev;
  end

  always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      ev_valid_q <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_next;
      count_q    <= count_d;
      head_q     <= head_d;
      ev_valid_q <= (count_d != '0);
      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  assign in_ready     = in_ready_q;
  assign sysex_active = sysex_q;
  assign ev_valid     = ev_valid_q;
  assign drop_cnt     = drop_q;
  assign {ev_type, ev_part_mask, ev_d1, ev_d2} = head_q;

endmodule

// File: tb/tb_midi_event_decoder.sv
// tb/tb_midi_event_decoder.sv - scoreboard bench for midi_event_decoder
module tb_midi_event_decoder;

  logic        CLOCK_25 = 1'b0;
  logic        reset_reg_N;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] part_ch;
  logic [3:0]  part_omni;
  logic [3:0]  part_en;
  logic        ev_valid;
  logic        ev_ready;
  logic [2:0]  ev_type;
  logic [3:0]  ev_part_mask;
  logic [6:0]  ev_d1;
  logic [13:0] ev_d2;
  logic [7:0]  drop_cnt;
  logic        sysex_active;

  int n_cmp = 0;
  int n_fail = 0;
  logic [27:0] exp_q[$];

  midi_event_decoder #(.NUM_PARTS(4), .FIFO_DEPTH(8), .FIFO_AW(3)) dut (
    .CLOCK_25(CLOCK_25), .reset_reg_N(reset_reg_N), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .part_ch(part_ch), .part_omni(part_omni), .part_en(part_en),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type), .ev_part_mask(ev_part_mask),
    .ev_d1(ev_d1), .ev_d2(ev_d2), .drop_cnt(drop_cnt), .sysex_active(sysex_active)
  );

  always #5 CLOCK_25 = ~CLOCK_25;

  function automatic logic [27:0] mk(input logic [2:0] t, input logic [3:0] m,
                                     input logic [6:0] d1, input logic [13:0] d2);
    return {t, m, d1, d2};
  endfunction

  // Scoreboard: every popped head must match the oldest expected event.
  always @(negedge CLOCK_25) begin
    if (reset_reg_N && ev_valid && ev_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got %h, none expected", {ev_type, ev_part_mask, ev_d1, ev_d2});
      end else begin
        logic [27:0] e;
        e = exp_q.pop_front();
        if ({ev_type, ev_part_mask, ev_d1, ev_d2} !== e) begin
          n_fail++;
          $display("FAIL event: got %h, expected %h", {ev_type, ev_part_mask, ev_d1, ev_d2}, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLOCK_25); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge CLOCK_25); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_drained(input string name);
    tick(4);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: %0d events still expected, 0 required", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    reset_reg_N = 1'b0;
    tick(2);
    n_cmp++;
    if ({in_ready, ev_valid, ev_type, ev_part_mask, ev_d1, ev_d2, drop_cnt, sysex_active} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b v=%b t=%h m=%h d1=%h d2=%h drop=%h sx=%b, all zero required",
               in_ready, ev_valid, ev_type, ev_part_mask, ev_d1, ev_d2, drop_cnt, sysex_active);
    end
    reset_reg_N = 1'b1;
    tick(1);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL in_ready_after_reset: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_note_on;
    exp_q.push_back(mk(3'd1, 4'b0001, 7'h3C, 14'h64));
    send_byte(8'h90);
    send_byte(8'h3C);
    n_cmp++;
    if (ev_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL note_on_early: ev_valid %b, required 0", ev_valid);
    end
    send_byte(8'h64);
    n_cmp++;
    if (ev_valid !== 1'b1 || ev_type !== 3'd1 || ev_d1 !== 7'h3C) begin
      n_fail++;
      $display("FAIL note_on_latency: v=%b t=%0d d1=%h, required v=1 t=1 d1=3c", ev_valid, ev_type, ev_d1);
    end
    check_drained("note_on");
  endtask

  task automatic test_running_status;
    exp_q.push_back(mk(3'd1, 4'b0010, 7'h40, 14'h50));
    exp_q.push_back(mk(3'd0, 4'b0010, 7'h40, 14'h00));
    foreach (exp_q[i]) ;
    send_byte(8'h93); send_byte(8'h40); send_byte(8'h50); send_byte(8'h40); send_byte(8'h00);
    check_drained("running_status");
  endtask

  task automatic test_pitch_realtime;
    exp_q.push_back(mk(3'd4, 4'b0001, 7'h00, 14'h2085));
    send_byte(8'hE0); send_byte(8'hF8); send_byte(8'h05); send_byte(8'hFE); send_byte(8'h41);
    check_drained("pitch_realtime");
  endtask

  task automatic test_sysex_abort;
    send_byte(8'hF0);
    n_cmp++;
    if (sysex_active !== 1'b1) begin
      n_fail++;
      $display("FAIL sysex_start: got %b, required 1", sysex_active);
    end
    send_byte(8'h7E); send_byte(8'h01);
    n_cmp++;
    if (sysex_active !== 1'b1) begin
      n_fail++;
      $display("FAIL sysex_hold: got %b, required 1", sysex_active);
    end
    send_byte(8'hF7);
    n_cmp++;
    if (sysex_active !== 1'b0) begin
      n_fail++;
      $display("FAIL sysex_end: got %b, required 0", sysex_active);
    end
    send_byte(8'h3C);
    exp_q.push_back(mk(3'd2, 4'b0001, 7'h07, 14'h7F));
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'hB0); send_byte(8'h07); send_byte(8'h7F);
    check_drained("sysex_abort");
  endtask

  task automatic test_mask_and_note_off;
    send_byte(8'h85); send_byte(8'h30); send_byte(8'h20);
    part_omni = 4'b0100;
    part_en   = 4'b0111;
    exp_q.push_back(mk(3'd1, 4'b0100, 7'h30, 14'h20));
    send_byte(8'h95); send_byte(8'h30); send_byte(8'h20);
    tick(2);
    part_omni = 4'b0000;
    part_en   = 4'b0011;
    exp_q.push_back(mk(3'd0, 4'b0001, 7'h3C, 14'h22));
    send_byte(8'h80); send_byte(8'h3C); send_byte(8'h22);
    check_drained("mask_note_off");
  endtask

  task automatic test_overflow;
    ev_ready = 1'b0;
    send_byte(8'hC0);
    for (int i = 0; i < 11; i++) begin
      if (i < 8) exp_q.push_back(mk(3'd3, 4'b0001, 7'(8'h10 + i), 14'h0));
      send_byte(8'h10 + 8'(i));
    end
    n_cmp++;
    if (drop_cnt !== 8'd3 || ev_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_drop: drop=%0d v=%b, required drop=3 v=1", drop_cnt, ev_valid);
    end
    exp_q.push_back(mk(3'd3, 4'b0001, 7'h50, 14'h0));
    ev_ready = 1'b1;
    send_byte(8'h50);
    n_cmp++;
    if (drop_cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL full_pop_write: drop=%0d, required 3", drop_cnt);
    end
    tick(10);
    check_drained("overflow");
  endtask

  task automatic test_reset_mid;
    ev_ready = 1'b0;
    send_byte(8'hC0); send_byte(8'h22);
    send_byte(8'h90); send_byte(8'h3C);
    reset_reg_N = 1'b0;
    #1;
    n_cmp++;
    if (ev_valid !== 1'b0 || drop_cnt !== 8'd0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: v=%b drop=%0d rdy=%b, required 0 0 0", ev_valid, drop_cnt, in_ready);
    end
    tick(2);
    reset_reg_N = 1'b1;
    tick(1);
    ev_ready = 1'b1;
    send_byte(8'h64);
    tick(4);
    n_cmp++;
    if (ev_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lone_data: ev_valid %b, required 0", ev_valid);
    end
    check_drained("reset_mid");
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = 8'h00;
    part_ch   = 16'h0030;
    part_omni = 4'b0000;
    part_en   = 4'b0011;
    ev_ready  = 1'b1;
    test_reset;
    test_note_on;
    test_running_status;
    test_pitch_realtime;
    test_sysex_abort;
    test_mask_and_note_off;
    test_overflow;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
